// File: rtl/clk_rst_ctrl.sv
// Board clock/reset sequencer: pulses the MMCM reset, waits for lock, then releases the SoC reset.
// Optional button debounce is enabled by defining CLK_RST_CTRL_DEBOUNCE_EN.
module clk_rst_ctrl #(
    parameter int unsigned PLL_RST_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned SETTLE_CYCLES   = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_i,
    input  logic       pll_locked_i,
    output logic       pll_rst_o,
    output logic       soc_rst_n_o,
    output logic [1:0] state_o,
    output logic [3:0] retry_cnt_o,
    output logic       lock_fail_o
);

    localparam int unsigned MAX_AB     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                         : LOCK_TIMEOUT;
    localparam int unsigned MAX_CYCLES = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StAssert   = 2'b00,
        StLockWait = 2'b01,
        StSettle   = 2'b10,
        StRun      = 2'b11
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       retry_q;
    logic             fail_q;
    logic             pll_rst_q;
    logic             soc_rst_n_q;

    logic [1:0] btn_sync_q;
    logic [1:0] lock_sync_q;
    logic       btn_s;
    logic       lock_s;
    logic       btn_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_sync_q  <= 2'b00;
            lock_sync_q <= 2'b00;
        end else begin
            btn_sync_q  <= {btn_sync_q[0], btn_i};
            lock_sync_q <= {lock_sync_q[0], pll_locked_i};
        end
    end

    assign btn_s  = btn_sync_q[1];
    assign lock_s = lock_sync_q[1];

`ifdef CLK_RST_CTRL_DEBOUNCE_EN
    localparam int unsigned      DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q;

    // The counter only runs while the synchronized level disagrees with the accepted one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            btn_q    <= 1'b0;
        end else if (btn_s == btn_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_q <= '0;
            btn_q    <= btn_s;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end
`else
    logic [31:0] unused_db_cfg;
    assign unused_db_cfg = DEBOUNCE_CYCLES;
    assign btn_q         = btn_s;
`endif

    // Reset outputs are registered alongside the state so they never glitch on multi-bit
    // state changes (e.g. LOCK_WAIT -> SETTLE flips both state bits).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StAssert;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            fail_q      <= 1'b0;
            pll_rst_q   <= 1'b1;
            soc_rst_n_q <= 1'b0;
        end else if (btn_q) begin
            state_q     <= StAssert;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            soc_rst_n_q <= 1'b0;
        end else begin
            case (state_q)
                StAssert: begin
                    if (cnt_q == PLL_LAST) begin
                        state_q   <= StLockWait;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StLockWait: begin
                    if (lock_s) begin
                        state_q <= StSettle;
                        cnt_q   <= '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_q   <= StAssert;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        fail_q    <= 1'b1;
                        if (retry_q != 4'd15) begin
                            retry_q <= retry_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (!lock_s) begin
                        state_q   <= StAssert;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q     <= StRun;
                        cnt_q       <= '0;
                        soc_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_q     <= StAssert;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        soc_rst_n_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StAssert;
                    cnt_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    soc_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign soc_rst_n_o = soc_rst_n_q;
    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;
    assign lock_fail_o = fail_q;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Self-checking bench for clk_rst_ctrl: directed scenarios plus randomized lock/button/reset
// traffic, all checked against a timestamp-based reference model.
module tb_clk_rst_ctrl;

    localparam int PLL = 4;
    localparam int TO  = 32;
    localparam int SET = 8;
    localparam int DB  = 4;

    localparam int PH_ASSERT = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_RUN    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_i = 1'b0;
    logic       pll_locked_i = 1'b0;
    logic       pll_rst_o;
    logic       soc_rst_n_o;
    logic [1:0] state_o;
    logic [3:0] retry_cnt_o;
    logic       lock_fail_o;

    clk_rst_ctrl #(
        .PLL_RST_CYCLES (PLL),
        .LOCK_TIMEOUT   (TO),
        .SETTLE_CYCLES  (SET),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (btn_i),
        .pll_locked_i(pll_locked_i),
        .pll_rst_o   (pll_rst_o),
        .soc_rst_n_o (soc_rst_n_o),
        .state_o     (state_o),
        .retry_cnt_o (retry_cnt_o),
        .lock_fail_o (lock_fail_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase plus the edge index at which it was entered.
    int cyc = 0;
    int m_phase = PH_ASSERT;
    int m_enter = 0;
    int m_retry = 0;
    int m_fail = 0;
    int m_btnq = 0;
    int m_brun = 0;
    int m_btn_used = 0;
    bit lock_hist[$];
    bit btn_hist[$];

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic go(input int ph);
        m_phase = ph;
        m_enter = cyc;
    endtask

    task automatic model_edge();
        bit lock_s;
        bit btn_s;
        bit btn_act;
        int held;
        cyc++;
        if (!rst_n) begin
            go(PH_ASSERT);
            m_retry = 0;
            m_fail = 0;
            m_btnq = 0;
            m_brun = 0;
            m_btn_used = 0;
            lock_hist = {};
            btn_hist = {};
            repeat (2) begin
                lock_hist.push_back(1'b0);
                btn_hist.push_back(1'b0);
            end
            return;
        end
        lock_s = lock_hist[0];
        btn_s  = btn_hist[0];
`ifdef CLK_RST_CTRL_DEBOUNCE_EN
        btn_act = (m_btnq != 0);
`else
        btn_act = btn_s;
`endif
        m_btn_used = int'(btn_act);
        held = cyc - m_enter;
        if (btn_act) begin
            go(PH_ASSERT);
        end else begin
            case (m_phase)
                PH_ASSERT: if (held == PLL) go(PH_WAIT);
                PH_WAIT: begin
                    if (lock_s) go(PH_SETTLE);
                    else if (held == TO) begin
                        go(PH_ASSERT);
                        if (m_retry < 15) m_retry++;
                        m_fail = 1;
                    end
                end
                PH_SETTLE: begin
                    if (!lock_s) go(PH_ASSERT);
                    else if (held == SET) go(PH_RUN);
                end
                default: if (!lock_s) go(PH_ASSERT);
            endcase
        end
`ifdef CLK_RST_CTRL_DEBOUNCE_EN
        if (int'(btn_s) != m_btnq) begin
            m_brun++;
            if (m_brun == DB) begin
                m_btnq = int'(btn_s);
                m_brun = 0;
            end
        end else begin
            m_brun = 0;
        end
`endif
        void'(lock_hist.pop_front());
        lock_hist.push_back(pll_locked_i);
        void'(btn_hist.pop_front());
        btn_hist.push_back(btn_i);
    endtask

    task automatic check_all();
        check_val("state", int'(state_o), m_phase);
        check_val("pll_rst", int'(pll_rst_o), int'(m_phase == PH_ASSERT));
        check_val("soc_rst_n", int'(soc_rst_n_o), int'(m_phase == PH_RUN));
        check_val("retry_cnt", int'(retry_cnt_o), m_retry);
        check_val("lock_fail", int'(lock_fail_o), m_fail);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_state"}, int'(state_o), 0);
        check_val({tag, "_pll_rst"}, int'(pll_rst_o), 1);
        check_val({tag, "_soc_rst_n"}, int'(soc_rst_n_o), 0);
        check_val({tag, "_retry"}, int'(retry_cnt_o), 0);
        check_val({tag, "_fail"}, int'(lock_fail_o), 0);
    endtask

    task automatic wait_phase(input int target, input int bound);
        int i;
        for (i = 0; i < bound && m_phase != target; i++) tick();
        if (m_phase != target) check_val("wait_phase_timeout", m_phase, target);
    endtask

    task automatic wait_btn(input int level, input int bound);
        int i;
        for (i = 0; i < bound && m_btn_used != level; i++) tick();
        if (m_btn_used != level) check_val("wait_btn_timeout", m_btn_used, level);
    endtask

    initial begin
        int btn_left;
        int mode;

        // Scenario 1: lock tied high, full bring-up timeline.
        pll_locked_i = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            if (n > 1) tick();
            if (n <= 4) check_val("s1_pll_rst_hi", int'(pll_rst_o), 1);
            if (n == 5) check_val("s1_lock_wait", int'(state_o), 1);
            if (n == 6 || n == 13) check_val("s1_settle", int'(state_o), 2);
            if (n == 13) check_val("s1_soc_lo_c13", int'(soc_rst_n_o), 0);
            if (n == 14) check_val("s1_soc_hi_c14", int'(soc_rst_n_o), 1);
        end

        // Scenario 3: one-cycle lock drop in RUN.
        pll_locked_i = 1'b0;
        tick();
        pll_locked_i = 1'b1;
        check_val("s3_soc_d0", int'(soc_rst_n_o), 1);
        tick();
        check_val("s3_soc_d1", int'(soc_rst_n_o), 1);
        tick();
        check_val("s3_soc_d2", int'(soc_rst_n_o), 0);
        check_val("s3_retry", int'(retry_cnt_o), 0);
        repeat (20) tick();
        check_val("s3_rerun", int'(soc_rst_n_o), 1);

        // Scenario 4: lock drop while SETTLE count is 5.
        pll_locked_i = 1'b0;
        tick();
        pll_locked_i = 1'b1;
        wait_phase(PH_SETTLE, 40);
        repeat (3) tick();
        pll_locked_i = 1'b0;
        tick();
        pll_locked_i = 1'b1;
        tick();
        check_val("s4_still_settle", int'(state_o), 2);
        tick();
        check_val("s4_to_assert", int'(state_o), 0);
        repeat (5) tick();
        check_val("s4_settle_again", int'(state_o), 2);
        repeat (7) tick();
        check_val("s4_settle_full", int'(state_o), 2);
        tick();
        check_val("s4_run", int'(state_o), 3);

        // Scenario 5: button behaviour.
`ifdef CLK_RST_CTRL_DEBOUNCE_EN
        btn_i = 1'b1;
        repeat (3) tick();
        btn_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("s5_glitch_soc", int'(soc_rst_n_o), 1);
        end
        btn_i = 1'b1;
        repeat (10) tick();
        btn_i = 1'b0;
        check_val("s5_press_state", int'(state_o), 0);
        check_val("s5_press_soc", int'(soc_rst_n_o), 0);
`else
        btn_i = 1'b1;
        tick();
        btn_i = 1'b0;
        wait_btn(1, 10);
`endif
        wait_btn(0, 30);
        repeat (11) tick();
        check_val("s5_release_c12", int'(soc_rst_n_o), 0);
        tick();
        check_val("s5_release_c13", int'(soc_rst_n_o), 1);
        check_val("s5_retry", int'(retry_cnt_o), 0);
        check_val("s5_fail", int'(lock_fail_o), 0);

        // Scenario 2: lock never arrives.
        pll_locked_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            for (int i = 1; i <= 36; i++) begin
                tick();
                if (k == 1 && i == 35) check_val("s2_fail_before", int'(lock_fail_o), 0);
                if (soc_rst_n_o) check_val("s2_soc_lo", int'(soc_rst_n_o), 0);
            end
            check_val("s2_retry", int'(retry_cnt_o), (k < 15) ? k : 15);
            check_val("s2_fail", int'(lock_fail_o), 1);
        end

        // Scenario 6: reset in RUN clears sticky status.
        pll_locked_i = 1'b1;
        repeat (30) tick();
        check_val("s6_run", int'(soc_rst_n_o), 1);
        check_val("s6_fail_set", int'(lock_fail_o), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_values("s6");

        // Randomized traffic.
        btn_left = 0;
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) mode = $urandom_range(2);
            case (mode)
                0: pll_locked_i = ($urandom_range(99) < 98);
                1: pll_locked_i = 1'b0;
                default: pll_locked_i = ($urandom_range(99) < 70);
            endcase
            if (btn_left > 0) begin
                btn_i = 1'b1;
                btn_left--;
            end else begin
                btn_i = 1'b0;
                if ($urandom_range(99) == 0) btn_left = $urandom_range(12, 1);
            end
            rst_n = ($urandom_range(999) > 1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
